// File: rtl/pcs_mlane_pkg.sv
// pcs_mlane_pkg: link FSM state codes and default debounce constants shared by the link monitor.
package pcs_mlane_pkg;
  typedef enum logic [1:0] {DOWN = 2'd0, QUAL = 2'd1, UP = 2'd2, HOLD = 2'd3} link_state_t;
  localparam int unsigned DEF_TMR_W       = 23;
  localparam int unsigned DEF_LINK_UP_CYC = 6440000;
  localparam int unsigned DEF_LINK_DN_CYC = 0;
  function automatic logic is_link_up(input link_state_t s);
    return (s == UP) || (s == HOLD);
  endfunction
endpackage

// File: rtl/pcs_mlane_link_monitor_if.sv
// pcs_mlane_link_monitor_if: lane status inputs, read strobe and status/counter outputs of the link monitor; master drives lane inputs, slave is the monitor.
interface pcs_mlane_link_monitor_if
  import pcs_mlane_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int CNT_W  = 16,
  parameter int ERR_W  = 8,
  parameter int FLAP_W = 8
);
  logic [LANES-1:0]        block_lock;
  logic [LANES-1:0]        hi_ber;
  logic [LANES-1:0]        rx_decode_error;
  logic                    status_read;
  logic [LANES-1:0]        pcs_status;
  logic [LANES-1:0]        pcs_status_ll;
  logic                    all_status;
  logic [LANES*CNT_W-1:0]  ber_count;
  logic [LANES*ERR_W-1:0]  errored_block_count;
  logic [FLAP_W-1:0]       link_flap_count;
  logic                    link_up;
  link_state_t             link_state;
  modport master (
    output block_lock, hi_ber, rx_decode_error, status_read,
    input  pcs_status, pcs_status_ll, all_status, ber_count, errored_block_count,
           link_flap_count, link_up, link_state
  );
  modport slave (
    input  block_lock, hi_ber, rx_decode_error, status_read,
    output pcs_status, pcs_status_ll, all_status, ber_count, errored_block_count,
           link_flap_count, link_up, link_state
  );
endinterface

// File: rtl/pcs_sat_cnt_snap.sv
// pcs_sat_cnt_snap: saturating event counter cleared by rd, which also snapshots the pre-event value (ports: clk, rst, inc, rd, snap).
module pcs_sat_cnt_snap #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         rd,
  output logic [W-1:0] snap
);
  logic [W-1:0] live;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live <= '0;
      snap <= '0;
    end else begin
      live <= rd ? W'(inc) : (inc && !(&live)) ? live + W'(1) : live;
      if (rd) snap <= live;
    end
  end
endmodule

// File: rtl/pcs_mlane_link_monitor.sv
// pcs_mlane_link_monitor: per-lane PCS status with latching-low copies, clear-on-read error counters and a debounced aggregate link FSM (ports: clk, rst, bus slave).
module pcs_mlane_link_monitor
  import pcs_mlane_pkg::*;
#(
  parameter int          LANES       = 4,
  parameter int          CNT_W       = 16,
  parameter int          ERR_W       = 8,
  parameter int          FLAP_W      = 8,
  parameter int          TMR_W       = DEF_TMR_W,
  parameter int unsigned LINK_UP_CYC = DEF_LINK_UP_CYC,
  parameter int unsigned LINK_DN_CYC = DEF_LINK_DN_CYC
) (
  input logic clk,
  input logic rst,
  pcs_mlane_link_monitor_if.slave bus
);
  localparam logic [TMR_W-1:0] UP_LAST = TMR_W'(LINK_UP_CYC - 1);
  localparam logic [TMR_W-1:0] DN_LAST = TMR_W'((LINK_DN_CYC == 0) ? 0 : LINK_DN_CYC - 1);
  localparam logic             DN_NOW  = (LINK_DN_CYC == 0);
  logic [LANES-1:0]       raw;
  logic                   all_ok;
  logic [LANES-1:0]       status_q;
  logic [LANES-1:0]       ll_q;
  logic                   all_q;
  link_state_t            state, state_n;
  logic [TMR_W-1:0]       timer, timer_n;
  logic                   flap_inc;
  logic [LANES*CNT_W-1:0] ber_snap;
  logic [LANES*ERR_W-1:0] err_snap;
  logic [FLAP_W-1:0]      flap_snap;
  assign raw    = bus.block_lock & ~bus.hi_ber;
  assign all_ok = &raw;
  // A low lane wins over a read so a fault seen in the read cycle is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= '0;
      ll_q     <= '0;
      all_q    <= 1'b0;
    end else begin
      status_q <= raw;
      ll_q     <= raw & (ll_q | {LANES{bus.status_read}});
      all_q    <= all_ok;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DOWN;
      timer <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
    end
  end
  always_comb begin
    state_n  = state;
    flap_inc = 1'b0;
    unique case (state)
      DOWN: state_n = all_ok ? QUAL : DOWN;
      QUAL: state_n = !all_ok ? DOWN : (timer == UP_LAST) ? UP : QUAL;
      UP: begin
        state_n  = all_ok ? UP : DN_NOW ? DOWN : HOLD;
        flap_inc = !all_ok && DN_NOW;
      end
      HOLD: begin
        state_n  = all_ok ? UP : (timer == DN_LAST) ? DOWN : HOLD;
        flap_inc = !all_ok && (timer == DN_LAST);
      end
      default: state_n = DOWN;
    endcase
    timer_n = (state_n != state) ? '0 : (state == QUAL || state == HOLD) ? timer + TMR_W'(1) : timer;
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pcs_sat_cnt_snap #(.W(CNT_W)) u_ber (
      .clk  (clk),
      .rst  (rst),
      .inc  (bus.block_lock[i] & bus.hi_ber[i]),
      .rd   (bus.status_read),
      .snap (ber_snap[i*CNT_W +: CNT_W])
    );
    pcs_sat_cnt_snap #(.W(ERR_W)) u_err (
      .clk  (clk),
      .rst  (rst),
      .inc  (bus.block_lock[i] & bus.rx_decode_error[i]),
      .rd   (bus.status_read),
      .snap (err_snap[i*ERR_W +: ERR_W])
    );
  end
  pcs_sat_cnt_snap #(.W(FLAP_W)) u_flap (
    .clk  (clk),
    .rst  (rst),
    .inc  (flap_inc),
    .rd   (bus.status_read),
    .snap (flap_snap)
  );
  assign bus.pcs_status          = status_q;
  assign bus.pcs_status_ll       = ll_q;
  assign bus.all_status          = all_q;
  assign bus.ber_count           = ber_snap;
  assign bus.errored_block_count = err_snap;
  assign bus.link_flap_count     = flap_snap;
  assign bus.link_state          = state;
  assign bus.link_up             = is_link_up(state);
endmodule

// File: tb/tb_pcs_mlane_link_monitor.sv
// tb_pcs_mlane_link_monitor: table-driven status checks plus hand-written FSM, counter and reset sequences.
module tb_pcs_mlane_link_monitor;
  import pcs_mlane_pkg::*;
  localparam int L = 4, CW = 8, EW = 8, FW = 8;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  pcs_mlane_link_monitor_if #(.LANES(L), .CNT_W(CW), .ERR_W(EW), .FLAP_W(FW)) bus_a ();
  pcs_mlane_link_monitor_if #(.LANES(L), .CNT_W(CW), .ERR_W(EW), .FLAP_W(FW)) bus_b ();
  assign bus_b.block_lock      = bus_a.block_lock;
  assign bus_b.hi_ber          = bus_a.hi_ber;
  assign bus_b.rx_decode_error = bus_a.rx_decode_error;
  assign bus_b.status_read     = bus_a.status_read;
  pcs_mlane_link_monitor #(.LANES(L), .CNT_W(CW), .ERR_W(EW), .FLAP_W(FW), .TMR_W(8),
    .LINK_UP_CYC(16), .LINK_DN_CYC(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  pcs_mlane_link_monitor #(.LANES(L), .CNT_W(CW), .ERR_W(EW), .FLAP_W(FW), .TMR_W(8),
    .LINK_UP_CYC(16), .LINK_DN_CYC(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  typedef struct {
    logic [3:0] bl;
    logic [3:0] hb;
    logic       rd;
    logic [3:0] st;
    logic [3:0] ll;
    logic       all;
  } vec_t;
  vec_t tbl[12];
  int checks = 0;
  int failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask
  task automatic drv(input logic [3:0] bl, input logic [3:0] hb, input logic [3:0] er, input logic rd);
    bus_a.block_lock      = bl;
    bus_a.hi_ber          = hb;
    bus_a.rx_decode_error = er;
    bus_a.status_read     = rd;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    drv(4'h0, 4'h0, 4'h0, 1'b0);
    steps(2);
    rst = 1'b0;
  endtask
  initial begin
    tbl[0]  = '{4'hF, 4'h0, 1'b0, 4'hF, 4'h0, 1'b1};
    tbl[1]  = '{4'hF, 4'h0, 1'b1, 4'hF, 4'hF, 1'b1};
    tbl[2]  = '{4'hE, 4'h0, 1'b0, 4'hE, 4'hE, 1'b0};
    tbl[3]  = '{4'hF, 4'h0, 1'b0, 4'hF, 4'hE, 1'b1};
    tbl[4]  = '{4'hE, 4'h0, 1'b1, 4'hE, 4'hE, 1'b0};
    tbl[5]  = '{4'hF, 4'h0, 1'b1, 4'hF, 4'hF, 1'b1};
    tbl[6]  = '{4'hF, 4'h4, 1'b0, 4'hB, 4'hB, 1'b0};
    tbl[7]  = '{4'hF, 4'h0, 1'b0, 4'hF, 4'hB, 1'b1};
    tbl[8]  = '{4'h7, 4'h0, 1'b1, 4'h7, 4'h7, 1'b0};
    tbl[9]  = '{4'hF, 4'h2, 1'b1, 4'hD, 4'hD, 1'b0};
    tbl[10] = '{4'hF, 4'h0, 1'b1, 4'hF, 4'hF, 1'b1};
    tbl[11] = '{4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0};
    rst = 1'b1;
    drv(4'hF, 4'h0, 4'hF, 1'b1);
    steps(2);
    chk("rst_status", bus_a.pcs_status, 0);
    chk("rst_ll", bus_a.pcs_status_ll, 0);
    chk("rst_all", bus_a.all_status, 0);
    chk("rst_ber", bus_a.ber_count, 0);
    chk("rst_err", bus_a.errored_block_count, 0);
    chk("rst_flap", bus_a.link_flap_count, 0);
    chk("rst_up", bus_a.link_up, 0);
    chk("rst_state", bus_a.link_state, 0);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drv(tbl[i].bl, tbl[i].hb, 4'h0, tbl[i].rd);
      step();
      chk($sformatf("tbl%0d_status", i), bus_a.pcs_status, tbl[i].st);
      chk($sformatf("tbl%0d_ll", i), bus_a.pcs_status_ll, tbl[i].ll);
      chk($sformatf("tbl%0d_all", i), bus_a.all_status, tbl[i].all);
    end
    do_reset();
    drv(4'hF, 4'h0, 4'h0, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      step();
      chk($sformatf("qual_state_k%0d", k), bus_a.link_state, (k >= 17) ? 2 : 1);
      chk($sformatf("qual_up_k%0d", k), bus_a.link_up, (k >= 17) ? 1 : 0);
    end
    chk("qual_b_state", bus_b.link_state, 2);
    do_reset();
    drv(4'hF, 4'h0, 4'h0, 1'b0);
    steps(8);
    chk("glitch_pre_state", bus_a.link_state, 1);
    drv(4'hF, 4'h4, 4'h0, 1'b0);
    step();
    chk("glitch_state", bus_a.link_state, 0);
    drv(4'hF, 4'h0, 4'h0, 1'b0);
    steps(16);
    chk("glitch_up_16", bus_a.link_up, 0);
    step();
    chk("glitch_up_17", bus_a.link_up, 1);
    chk("glitch_b_up", bus_b.link_up, 1);
    drv(4'hE, 4'h0, 4'h0, 1'b0);
    step();
    chk("hold1_a_state", bus_a.link_state, 3);
    chk("hold1_a_up", bus_a.link_up, 1);
    chk("dn0_b_state", bus_b.link_state, 0);
    chk("dn0_b_up", bus_b.link_up, 0);
    steps(2);
    chk("hold3_a_up", bus_a.link_up, 1);
    drv(4'hF, 4'h0, 4'h0, 1'b0);
    step();
    chk("hold_recover_state", bus_a.link_state, 2);
    drv(4'hF, 4'h0, 4'h0, 1'b1);
    step();
    drv(4'hF, 4'h0, 4'h0, 1'b0);
    chk("rd1_a_flap", bus_a.link_flap_count, 0);
    chk("rd1_b_flap", bus_b.link_flap_count, 1);
    drv(4'hE, 4'h0, 4'h0, 1'b0);
    steps(4);
    chk("hold4_a_up", bus_a.link_up, 1);
    step();
    chk("hold5_a_up", bus_a.link_up, 0);
    chk("hold5_a_state", bus_a.link_state, 0);
    drv(4'hF, 4'h0, 4'h0, 1'b1);
    step();
    drv(4'hF, 4'h0, 4'h0, 1'b0);
    chk("rd2_a_flap", bus_a.link_flap_count, 1);
    chk("rd2_b_flap", bus_b.link_flap_count, 0);
    steps(16);
    chk("requal_b_state", bus_b.link_state, 2);
    drv(4'hE, 4'h0, 4'h0, 1'b0);
    step();
    drv(4'hF, 4'h0, 4'h0, 1'b0);
    step();
    steps(16);
    chk("requal2_b_state", bus_b.link_state, 2);
    drv(4'hE, 4'h0, 4'h0, 1'b1);
    step();
    chk("flap_rd_b_snap", bus_b.link_flap_count, 1);
    chk("flap_rd_a_snap", bus_a.link_flap_count, 0);
    drv(4'hF, 4'h0, 4'h0, 1'b0);
    step();
    drv(4'hF, 4'h0, 4'h0, 1'b1);
    step();
    drv(4'hF, 4'h0, 4'h0, 1'b0);
    chk("flap_next_b_snap", bus_b.link_flap_count, 1);
    chk("flap_next_a_snap", bus_a.link_flap_count, 0);
    steps(16);
    chk("pre_hold_a_state", bus_a.link_state, 2);
    drv(4'hE, 4'h0, 4'h0, 1'b0);
    step();
    chk("mid_hold_state", bus_a.link_state, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_state", bus_a.link_state, 0);
    chk("async_rst_up", bus_a.link_up, 0);
    chk("async_rst_flap", bus_a.link_flap_count, 0);
    chk("async_rst_status", bus_a.pcs_status, 0);
    do_reset();
    drv(4'hE, 4'h3, 4'h0, 1'b0);
    steps(300);
    drv(4'hE, 4'h0, 4'h0, 1'b1);
    step();
    drv(4'hF, 4'h0, 4'h0, 1'b0);
    chk("ber_sat", bus_a.ber_count, 32'h0000FF00);
    step();
    drv(4'hF, 4'h0, 4'h0, 1'b1);
    step();
    drv(4'hB, 4'h0, 4'h0, 1'b0);
    chk("ber_clear", bus_a.ber_count, 0);
    for (int k = 0; k < 5; k++) begin
      drv(4'hB, 4'h0, 4'hC, 1'b0);
      step();
      drv(4'hB, 4'h0, 4'h0, 1'b0);
      step();
    end
    drv(4'hB, 4'h0, 4'h8, 1'b1);
    step();
    chk("err_rd_snap", bus_a.errored_block_count, 32'h05000000);
    drv(4'hB, 4'h0, 4'h0, 1'b1);
    step();
    drv(4'hB, 4'h0, 4'h0, 1'b0);
    chk("err_next_snap", bus_a.errored_block_count, 32'h01000000);
    chk("err_ber_snap", bus_a.ber_count, 0);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pcs_mlane_link_monitor.md
# pcs_mlane_link_monitor

Multi-lane, parametrised PCS link-status and error monitor for the 10G/40G PCS receive path, sitting after block lock and BER state machines of each lane. Generates per-lane Clause 49 PCS status with latching-low copies, clear-on-read error counters with snapshot, and an aggregate debounced link state machine. The link state machine has separate link-up qualification and link-down hold-off timers, and counts link flaps. Read strobes come from the MDIO/register block.

## Interface
- LANES, 4: number of PCS lanes monitored (1..20).
- CNT_W, 16: width of per-lane BER cycle counter.
- ERR_W, 8: width of per-lane errored-block counter.
- FLAP_W, 8: width of link-flap counter.
- TMR_W, 23: width of shared debounce timer.
- LINK_UP_CYC, 6440000: cycles all lanes must be good before link_up rises (~10 ms at 644 MHz); must be ≥1.
- LINK_DN_CYC, 0: cycles a fault must persist in UP before link_up falls; 0 = immediate.

Ports:
- clk  in  1  PCS receive clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- block_lock  in  LANES  per-lane block lock.
- hi_ber  in  LANES  per-lane high-BER flag.
- rx_decode_error  in  LANES  per-lane errored-block pulse, one per block.
- status_read  in  1  single-cycle read strobe: clears latches, snapshots counters.
- pcs_status  out  LANES  registered block_lock & ~hi_ber.
- pcs_status_ll  out  LANES  latching-low copy of pcs_status.
- all_status  out  1  registered AND of all raw lane statuses.
- ber_count  out  LANES*CNT_W  snapshot of hi_ber cycles; lane i at [i*CNT_W +: CNT_W].
- errored_block_count  out  LANES*ERR_W  snapshot of errored blocks, same packing.
- link_flap_count  out  FLAP_W  snapshot of UP→DOWN transitions.
- link_up  out  1  debounced aggregate link.
- link_state  out  2  current FSM state code.

## Operation
- raw_i = block_lock[i] & ~hi_ber[i]; all_ok = AND of raw over lanes.
- pcs_status_ll[i]: raw_i=0 → 0, regardless of status_read. Otherwise, status_read → 1. Otherwise hold.
- Live counters are internal, one per lane per type plus the flap counter. All saturate at all-ones. None wrap.
- BER live count increments each cycle with block_lock[i] & hi_ber[i].
- Errored-block live count increments on rx_decode_error[i] & block_lock[i].
- Counter clearing happens only on status_read, never on lock loss.
- On status_read, each output snapshot takes that counter's live value before this cycle's event. Each live counter loads 1 if an event occurs this cycle, else 0.
- Snapshots hold between reads.
- FSM states (link_state): DOWN=0, QUAL=1, UP=2, HOLD=3. A single timer is cleared on every state change.
- DOWN: all_ok → QUAL.
- QUAL: !all_ok → DOWN. Else, when timer == LINK_UP_CYC-1 → UP. Else timer++.
- UP: !all_ok → HOLD if LINK_DN_CYC>0. If LINK_DN_CYC=0, → DOWN and flap++.
- HOLD: all_ok → UP, no flap. Else, when timer == LINK_DN_CYC-1 → DOWN and flap++. Else timer++.
- link_up = 1 in UP and HOLD.
- A flap increment coinciding with status_read obeys the live-counter read rule: snapshot gets the old value, live counter = 1.

## Timing
- Reset values: pcs_status=0, pcs_status_ll=0, all_status=0, all counters and snapshots=0, link_flap_count=0, link_up=0, link_state=DOWN, timer=0.
- pcs_status, pcs_status_ll, all_status: 1 cycle after input change.
- Snapshot outputs change the cycle after status_read. Reads on consecutive cycles each re-snapshot.
- link_up rises LINK_UP_CYC+1 cycles after all_ok first goes high: one cycle DOWN→QUAL, then LINK_UP_CYC cycles in QUAL.
- With LINK_DN_CYC=0, link_up falls one cycle after all_ok falls. Otherwise it falls LINK_DN_CYC+1 cycles after.
- A single-cycle all_ok dropout in QUAL restarts qualification from DOWN.
- Reset asserted mid-qualification or mid-HOLD immediately forces DOWN with all values at reset.

## Structure
- Shared package pcs_mlane_pkg holds the state codes (DOWN/QUAL/UP/HOLD, 2-bit) and the default timer constants.
- Sub-module pcs_sat_cnt_snap (param W) implements one saturating live counter with read-snapshot. It is instantiated 2*LANES+1 times via generate.
- The FSM and latching-low logic stay in the top module.

## Test plan
- Reset, then LANES=4 all locked, no hi_ber, LINK_UP_CYC=16: link_up=1 exactly 17 cycles after inputs settle; link_state passes 0→1→2.
- QUAL cycle 8, lane 2 hi_ber pulsed 1 cycle: link_state returns to 0. link_up=1 only 17 cycles after the glitch clears.
- LINK_DN_CYC=4, in UP, lane 0 loses lock for 3 cycles: link_up stays 1, flap unchanged. Lose lock for 5 cycles: link_up falls, a read returns link_flap_count=1.
- Lane 1 hi_ber held for 300 cycles with ERR_W/CNT_W=8, then status_read: ber_count lane1=255 (saturated). Next read with no events gives 0.
- rx_decode_error on lane 3 asserted in the same cycle as status_read, after 5 prior errors: snapshot=5. Next read=1.
- Lane 0 drops lock then recovers, and pcs_status_ll[0] stays 0 until status_read. status_read while raw low leaves it at 0. The next read, with raw high, sets it to 1.
